// File: rtl/enc_pkg.sv
// rtl/enc_pkg.sv - shared types and constants for the encoder scan controller
package enc_pkg;

    localparam int VALUE_W = 8;
    localparam int CH_W    = 3;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SAMPLE = 3'd1,
        DECODE = 3'd2,
        WRITE  = 3'd3,
        LOAD   = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        STEP_NONE = 2'd0,
        STEP_INC  = 2'd1,
        STEP_DEC  = 2'd2
    } step_e;

endpackage

// File: rtl/quad_step_decode.sv
// rtl/quad_step_decode.sv - combinational quadrature step decoder shared by all channels
module quad_step_decode
    import enc_pkg::*;
(
    input  logic [3:0] key_i,
    output step_e      step_o
);

    // key is {a, prev_a, b, prev_b}
    always_comb begin
        step_o = STEP_NONE;
        case (key_i)
            4'b1000, 4'b0111: step_o = STEP_INC;
            4'b0010, 4'b1101: step_o = STEP_DEC;
            default:          step_o = STEP_NONE;
        endcase
    end

endmodule

// File: rtl/enc_scan_ctrl.sv
// rtl/enc_scan_ctrl.sv - round-robin encoder scanner with host presets; ENC_SATURATE_EN selects saturating arithmetic
module enc_scan_ctrl
    import enc_pkg::*;
#(
    parameter int NUM_CH   = 3,
    parameter int SCAN_DIV = 8
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_CH-1:0]         enc_a,
    input  logic [NUM_CH-1:0]         enc_b,
    input  logic                      load_req,
    input  logic [CH_W-1:0]           load_ch,
    input  logic [VALUE_W-1:0]        load_val,
    output logic                      load_ack,
    output logic [VALUE_W*NUM_CH-1:0] values,
    output logic                      upd_valid,
    output logic [CH_W-1:0]           upd_ch,
    output logic [VALUE_W-1:0]        upd_val
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_CH - 1);
    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);

    logic [NUM_CH-1:0]  a_s1_q, a_s2_q, b_s1_q, b_s2_q;
    logic [NUM_CH-1:0]  prev_a_q, prev_b_q;
    logic               smp_a_q, smp_b_q;
    logic [PTR_W-1:0]   ptr_q;
    logic [CNT_W-1:0]   scan_cnt_q;
    logic               tick_pend_q, tick_pend_d;
    state_e             state_q, state_d;
    step_e              step_q, step_dec;
    logic [VALUE_W-1:0] value_q [NUM_CH];
    logic               load_ack_q, upd_valid_q;
    logic [CH_W-1:0]    upd_ch_q;
    logic [VALUE_W-1:0] upd_val_q;

    logic               tick, slot_start, sat_hit, step_wr;
    logic [VALUE_W-1:0] cur_val, nxt_val;

    assign tick = (scan_cnt_q == '0);

    quad_step_decode u_dec (
        .key_i  ({smp_a_q, prev_a_q[ptr_q], smp_b_q, prev_b_q[ptr_q]}),
        .step_o (step_dec)
    );

    always_comb begin
        state_d    = state_q;
        slot_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_req) begin
                    state_d = LOAD;
                end else if (tick || tick_pend_q) begin
                    state_d    = SAMPLE;
                    slot_start = 1'b1;
                end
            end
            SAMPLE:  state_d = DECODE;
            DECODE:  state_d = WRITE;
            WRITE:   state_d = IDLE;
            LOAD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // a tick not consumed by a slot start this cycle is remembered
        tick_pend_d = slot_start ? 1'b0 : (tick | tick_pend_q);
    end

    always_comb begin
        cur_val = value_q[ptr_q];
        nxt_val = (step_q == STEP_INC) ? cur_val + VALUE_W'(1) : cur_val - VALUE_W'(1);
`ifdef ENC_SATURATE_EN
        sat_hit = ((step_q == STEP_INC) && (cur_val == '1)) ||
                  ((step_q == STEP_DEC) && (cur_val == '0));
`else
        sat_hit = 1'b0;
`endif
        step_wr = (state_q == WRITE) && (step_q != STEP_NONE) && !sat_hit;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_s1_q      <= '0;
            a_s2_q      <= '0;
            b_s1_q      <= '0;
            b_s2_q      <= '0;
            prev_a_q    <= '0;
            prev_b_q    <= '0;
            smp_a_q     <= 1'b0;
            smp_b_q     <= 1'b0;
            ptr_q       <= '0;
            scan_cnt_q  <= '0;
            tick_pend_q <= 1'b0;
            step_q      <= STEP_NONE;
            load_ack_q  <= 1'b0;
            upd_valid_q <= 1'b0;
            upd_ch_q    <= '0;
            upd_val_q   <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                value_q[i] <= '0;
            end
        end else begin
            a_s1_q      <= enc_a;
            a_s2_q      <= a_s1_q;
            b_s1_q      <= enc_b;
            b_s2_q      <= b_s1_q;
            scan_cnt_q  <= tick ? CNT_W'(SCAN_DIV - 1) : scan_cnt_q - CNT_W'(1);
            tick_pend_q <= tick_pend_d;
            load_ack_q  <= 1'b0;
            upd_valid_q <= 1'b0;
            case (state_q)
                SAMPLE: begin
                    smp_a_q <= a_s2_q[ptr_q];
                    smp_b_q <= b_s2_q[ptr_q];
                end
                DECODE: begin
                    step_q          <= step_dec;
                    prev_a_q[ptr_q] <= smp_a_q;
                    prev_b_q[ptr_q] <= smp_b_q;
                end
                WRITE: begin
                    if (step_wr) begin
                        value_q[ptr_q] <= nxt_val;
                        upd_valid_q    <= 1'b1;
                        upd_ch_q       <= CH_W'(ptr_q);
                        upd_val_q      <= nxt_val;
                    end
                    ptr_q <= (ptr_q == LAST_PTR) ? '0 : ptr_q + PTR_W'(1);
                end
                LOAD: begin
                    load_ack_q <= 1'b1;
                    if (load_ch <= LAST_CH) begin
                        value_q[load_ch[PTR_W-1:0]] <= load_val;
                        upd_valid_q                 <= 1'b1;
                        upd_ch_q                    <= load_ch;
                        upd_val_q                   <= load_val;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        values = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            values[i*VALUE_W +: VALUE_W] = value_q[i];
        end
    end

    assign load_ack  = load_ack_q;
    assign upd_valid = upd_valid_q;
    assign upd_ch    = upd_ch_q;
    assign upd_val   = upd_val_q;

endmodule

// File: tb/tb_enc_scan_ctrl.sv
// tb/tb_enc_scan_ctrl.sv - self-checking bench for enc_scan_ctrl; honours ENC_SATURATE_EN
module tb_enc_scan_ctrl;

    localparam int NUM_CH   = 3;
    localparam int SCAN_DIV = 8;
    localparam int FRAME    = NUM_CH * SCAN_DIV;
    localparam int W        = FRAME + 5;
`ifdef ENC_SATURATE_EN
    localparam int DEC_AT_ZERO = 0;
    localparam int LAST_CH_1   = 0;
    localparam int LAST_VAL_1  = 1;
    localparam int CH0_FINAL   = 0;
`else
    localparam int DEC_AT_ZERO = 255;
    localparam int LAST_CH_1   = 1;
    localparam int LAST_VAL_1  = 255;
    localparam int CH0_FINAL   = 254;
`endif

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic [NUM_CH-1:0]     enc_a, enc_b;
    logic                  load_req;
    logic [2:0]            load_ch;
    logic [7:0]            load_val;
    logic                  load_ack;
    logic [8*NUM_CH-1:0]   values;
    logic                  upd_valid;
    logic [2:0]            upd_ch;
    logic [7:0]            upd_val;

    always #5 clk = ~clk;

    enc_scan_ctrl #(.NUM_CH(NUM_CH), .SCAN_DIV(SCAN_DIV)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enc_a     (enc_a),
        .enc_b     (enc_b),
        .load_req  (load_req),
        .load_ch   (load_ch),
        .load_val  (load_val),
        .load_ack  (load_ack),
        .values    (values),
        .upd_valid (upd_valid),
        .upd_ch    (upd_ch),
        .upd_val   (upd_val)
    );

    int checks = 0;
    int errors = 0;
    int ne;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) ne <= 0;
        else          ne <= ne + 1;
    end

    // model: encoder levels, expected value per channel, FIFO of expected updates, value shadow
    logic [1:0] m_enc  [NUM_CH];
    logic [7:0] m_val  [NUM_CH];
    logic [7:0] shadow [NUM_CH];
    logic [7:0] pq     [NUM_CH][16];
    int         pwr    [NUM_CH];
    int         prd    [NUM_CH];
    int         ack_owed;
    int         cmp_c;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_enc[c]  = 2'b00;
            m_val[c]  = 8'd0;
            shadow[c] = 8'd0;
            pwr[c]    = 0;
            prd[c]    = 0;
        end
        ack_owed = 0;
    endtask

    // only a lone A change counts up, only a lone B change counts down, and only when A and B end up different
    function automatic int model_step(logic [1:0] o, logic [1:0] n);
        if (o[1] != n[1] && o[0] == n[0]) return (n[1] != n[0]) ? 1 : 0;
        if (o[0] != n[0] && o[1] == n[1]) return (n[1] != n[0]) ? -1 : 0;
        return 0;
    endfunction

    task automatic push(int ch, logic [7:0] v);
        pq[ch][pwr[ch] % 16] = v;
        pwr[ch]++;
        m_val[ch] = v;
    endtask

    task automatic drive(int ch, logic a, logic b);
        int s;
        int nv;
        enc_a[ch] = a;
        enc_b[ch] = b;
        s = model_step(m_enc[ch], {a, b});
        m_enc[ch] = {a, b};
        if (s != 0) begin
            nv = int'(m_val[ch]) + s;
`ifdef ENC_SATURATE_EN
            if (nv >= 0 && nv <= 255) push(ch, 8'(nv));
`else
            push(ch, 8'(nv & 255));
`endif
        end
    endtask

    task automatic enc_set(int ch, logic a, logic b);
        drive(ch, a, b);
        repeat (W) @(posedge clk);
        #1;
        chk($sformatf("latency_ch%0d", ch), pwr[ch] - prd[ch], 0);
    endtask

    task automatic to_edge(int e);
        while (ne < e + 1) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (upd_valid) begin
                cmp_c = int'(upd_ch);
                checks++;
                if (cmp_c >= NUM_CH || prd[cmp_c] == pwr[cmp_c]) begin
                    errors++;
                    $display("FAIL upd_unexpected: ch %0d val %0d with nothing pending", cmp_c, upd_val);
                end else begin
                    if (upd_val != pq[cmp_c][prd[cmp_c] % 16]) begin
                        errors++;
                        $display("FAIL upd_val ch%0d: got %0d expected %0d", cmp_c, upd_val, pq[cmp_c][prd[cmp_c] % 16]);
                    end
                    shadow[cmp_c] = pq[cmp_c][prd[cmp_c] % 16];
                    prd[cmp_c]++;
                end
            end
            if (load_ack) begin
                checks++;
                if (ack_owed == 0) begin
                    errors++;
                    $display("FAIL ack_unexpected: load_ack 1 expected 0");
                end else begin
                    ack_owed--;
                end
            end
            for (int c = 0; c < NUM_CH; c++) begin
                chk($sformatf("values_ch%0d", c), int'(values[c*8 +: 8]), int'(shadow[c]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    initial begin
        int e;
        int got;
        logic [1:0] tbl [12];
        int         tch [12];

        enc_a = '0; enc_b = '0; load_req = 1'b0; load_ch = '0; load_val = '0;
        reset_n = 1'b0;
        model_reset();

        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            enc_a = NUM_CH'($urandom);
            enc_b = NUM_CH'($urandom);
        end
        chk("reset_values", int'(values), 0);
        chk("reset_ack", load_ack, 0);
        chk("reset_upd_valid", upd_valid, 0);
        chk("reset_upd_ch", upd_ch, 0);
        chk("reset_upd_val", upd_val, 0);
        enc_a = '0; enc_b = '0;
        reset_n = 1'b1;

        // ch0 slot starting at edge 24 is in WRITE when reset hits
        to_edge(10);
        drive(0, 1'b1, 1'b0);
        to_edge(26);
        chk("pre_abort_upd", upd_valid, 0);
        reset_n = 1'b0;
        enc_a = NUM_CH'($urandom);
        enc_b = NUM_CH'($urandom);
        #1;
        chk("abort_values", int'(values), 0);
        chk("abort_upd_valid", upd_valid, 0);
        chk("abort_upd_val", upd_val, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        enc_a = '0; enc_b = '0;
        model_reset();
        drive(0, 1'b1, 1'b0);
        reset_n = 1'b1;
        repeat (W) @(posedge clk);
        #1;
        chk("inc_latency", pwr[0] - prd[0], 0);
        chk("inc_val0", int'(values[7:0]), 1);
        chk("inc_upd_ch", upd_ch, 0);
        chk("inc_upd_val", upd_val, 1);
        chk("inc_val1", int'(values[15:8]), 0);
        chk("inc_val2", int'(values[23:16]), 0);

        enc_set(1, 1'b0, 1'b1);
        chk("dec_at_zero", int'(values[15:8]), DEC_AT_ZERO);
        chk("dec_last_ch", upd_ch, LAST_CH_1);
        chk("dec_last_val", upd_val, LAST_VAL_1);

        enc_set(0, 1'b1, 1'b1);
        chk("zero_step_val0", int'(values[7:0]), 1);

        // tick at frame boundary e scans ch0; a load is raised for that same IDLE cycle
        e = ((ne + 2 * FRAME) / FRAME) * FRAME;
        to_edge(e - 20);
        drive(0, 1'b0, 1'b1);
        to_edge(e - 1);
        load_req = 1'b1; load_ch = 3'd2; load_val = 8'h80;
        push(2, 8'h80);
        ack_owed++;
        to_edge(e);
        chk("coll_ack_early", load_ack, 0);
        to_edge(e + 1);
        chk("coll_ack", load_ack, 1);
        load_req = 1'b0;
        chk("coll_val2", int'(values[23:16]), 128);
        chk("coll_upd_ch", upd_ch, 2);
        to_edge(e + 4);
        chk("deferred_early", upd_valid, 0);
        to_edge(e + 5);
        chk("deferred_upd", upd_valid, 1);
        chk("deferred_ch", upd_ch, 0);
        chk("deferred_val", upd_val, 2);
        repeat (W) @(posedge clk);
        #1;

        load_req = 1'b1; load_ch = 3'd5; load_val = 8'h33;
        ack_owed++;
        got = 0;
        for (int i = 0; i < 8 && got == 0; i++) begin
            @(posedge clk);
            #1;
            if (load_ack) begin
                got = 1;
                chk("oor_no_upd", upd_valid, 0);
            end
        end
        load_req = 1'b0;
        chk("oor_ack", got, 1);
        repeat (4) @(posedge clk);
        #1;
        chk("oor_val2", int'(values[23:16]), 128);

        reset_n = 1'b0;
        #1;
        model_reset();
        enc_a = '0; enc_b = '0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tbl = '{2'b10, 2'b01, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b10, 2'b11, 2'b01, 2'b00};
        tch = '{2, 0, 2, 0, 2, 0, 2, 0, 2, 2, 2, 2};
        for (int i = 0; i < 12; i++) begin
            enc_set(tch[i], tbl[i][1], tbl[i][0]);
        end
        chk("indep_val2", int'(values[23:16]), 4);
        chk("indep_val0", int'(values[7:0]), CH0_FINAL);
        chk("indep_val1", int'(values[15:8]), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/enc_scan_ctrl.md
# enc_scan_ctrl

Time-multiplexed quadrature-encoder controller for the RGB mixer. It serves NUM_CH rotary encoders, typically one per colour channel, by scanning them round-robin through a single shared step decoder, and keeps one 8-bit setting per channel. It also arbitrates host preset writes against scan writebacks. Its value bus feeds the PWM stage directly.

## Interface
Parameters:
- NUM_CH, 3: number of encoder channels, 1..8.
- SCAN_DIV, 8: clocks between slot starts, ≥4.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- enc_a  in  NUM_CH  encoder A inputs, asynchronous, bit i = channel i.
- enc_b  in  NUM_CH  encoder B inputs, asynchronous.
- load_req  in  1  host preset request, level; hold until ack.
- load_ch  in  3  preset target channel.
- load_val  in  8  preset value.
- load_ack  out  1  one-cycle pulse: preset serviced.
- values  out  8*NUM_CH  channel i value at bits [8i+7:8i].
- upd_valid  out  1  one-cycle pulse: a value changed.
- upd_ch  out  3  channel of the last change.
- upd_val  out  8  new value of the last change.

## Operation
- enc_a and enc_b each pass through a 2-flop synchronizer. The decoder sees only synchronized samples.
- scan_cnt counts down from SCAN_DIV-1. A tick is raised when scan_cnt==0. A tick that arrives while the FSM is not in IDLE sets tick_pend, which is cleared when the slot starts.
- FSM states and transitions:
  - IDLE → LOAD if load_req is high. Otherwise IDLE → SAMPLE on tick or tick_pend.
  - SAMPLE: capture {a,b} of channel ptr into smp. → DECODE.
  - DECODE: compute step from {smp_a, prev_a[ptr], smp_b, prev_b[ptr]}, then set prev[ptr] ← smp. → WRITE.
  - WRITE: apply step to value[ptr], advance ptr (NUM_CH-1 wraps to 0). → IDLE.
  - LOAD: if load_ch < NUM_CH, value[load_ch] ← load_val and pulse upd. Pulse load_ack in all cases. → IDLE.
- Step rule, with the key ordered {a, prev_a, b, prev_b}:
  - 1000 or 0111 → +1.
  - 0010 or 1101 → -1.
  - Every other combination → 0.
- WRITE with step 0 leaves the value unchanged and does not pulse upd_valid.
- Arithmetic is 8-bit. Overflow and underflow behaviour is set by the macro below.
- A load that targets an out-of-range channel is acked and then discarded.
- Precedence: a load has priority over a tick in the same IDLE cycle. The tick is deferred, not lost.

## Timing
- All outputs are registered. On reset every output is 0: values, load_ack, upd_valid, upd_ch, upd_val.
- Reset also clears prev_a/prev_b, smp, ptr, scan_cnt, tick_pend and both synchronizer stages, and returns the FSM to IDLE.
- Reset asserted mid-slot aborts the slot. No write occurs.
- The WRITE or LOAD edge updates values, load_ack, upd_valid, upd_ch and upd_val together. They are visible in the following cycle.
- A slot takes 3 clocks plus 1 return cycle. Hence SCAN_DIV ≥ 4, so that ticks are never dropped when no loads are pending.
- Input transition to value update takes 2 synchronizer clocks, plus up to NUM_CH·SCAN_DIV clocks of scan wait, plus 3 clocks.
- Load latency: 1 clock in LOAD after being seen in IDLE. In the worst case the load waits behind an in-flight slot, giving ≤5 clocks from request to ack.
- Encoder edges faster than one per NUM_CH·SCAN_DIV clocks may be missed. This is a documented limitation.

## Configuration
- ENC_SATURATE_EN defined: +1 at 255 holds 255, and -1 at 0 holds 0. A saturated hit produces no upd_valid.
- ENC_SATURATE_EN undefined: values wrap modulo 256, so 255+1 gives 0 and 0-1 gives 255. upd_valid pulses on every nonzero step.

## Structure
- Package enc_pkg holds:
  - The FSM state enum: IDLE, SAMPLE, DECODE, WRITE, LOAD.
  - VALUE_W = 8 and CH_W = 3.
  - The step encoding constants: STEP_NONE, STEP_INC, STEP_DEC.
- Sub-module quad_step_decode is combinational. It maps {a, prev_a, b, prev_b} to a step code and is shared by all channels.

## Test plan
- Reset: hold reset_n low mid-slot with random inputs → all outputs and values read 0, and the FSM is in IDLE after release.
- Increment on channel 0: drive A rising with B low (a previous A/B state of 00) → within NUM_CH·SCAN_DIV+5 clocks, value[0]=1, upd_valid pulses once, upd_ch=0, upd_val=1. Channels 1 and 2 stay at 0.
- Decrement at zero on channel 1 (B rises with A low):
  - Macro undefined → value[1]=255, upd_val=255.
  - Macro defined → value[1]=0 with no upd_valid.
- Load colliding with a tick: load_req with ch=2, val=0x80 asserted in the same IDLE cycle as a tick → load_ack pulses first, value[2]=0x80, and the deferred slot runs on the next cycle.
- Out-of-range load: load_ch=5 with NUM_CH=3 → load_ack pulses, no upd_valid, values unchanged.
- Independence: four increments on channel 2 and two decrements on channel 0, interleaved → value[2]=4 and value[0]=254 (wrap) or 0 (saturate).
